charactor_motion: RTL and testbench
===================================

// Module: charactor_motion
// PURPOSE
//  Per-frame sprite movement controller directly upstream of the VGA screen stage.
//  Each frame_tick, one button request becomes a candidate position in 320x240 sprite
//  space. The candidate is checked against the 20x15 tile map; a legal move is committed.
//  Drives charactor_h/charactor_v/charactor_dir into the screen stage and flags
//  TERMINAL arrival.
// PARAMETERS
//  START_H  24   reset X position (sprite centre, 320-space)
//  START_V  24   reset Y position (sprite centre, 240-space)
//  STEP     2    pixels moved per accepted frame
//  H_MIN    8    smallest legal X;  H_MAX  311  largest legal X
//  V_MIN    8    smallest legal Y;  V_MAX  231  largest legal Y
// PORTS
//  clk            in   1    system clock
//  rst            in   1    reset, synchronous, active-high
//  frame_tick     in   1    one-cycle pulse per video frame
//  game_en        in   1    high while top-level state is GAME
//  btn_up         in   1    level, debounced
//  btn_down       in   1    level, debounced
//  btn_left       in   1    level, debounced
//  btn_right      in   1    level, debounced
//  map            in   900  [0:899] tile map, 3 bits/tile, tile t at [3t..3t+2], MSB first
//  charactor_h    out  9    committed X
//  charactor_v    out  9    committed Y
//  charactor_dir  out  1    0 = facing left, 1 = facing right
//  on_terminal    out  1    sticky: committed tile is TERMINAL
//  move_done      out  1    one-cycle pulse, a frame's evaluation finished
//  busy           out  1    high in CALC/CHECK/COMMIT
// BEHAVIOUR
//  Reset values:
//  - charactor_h=START_H, charactor_v=START_V, charactor_dir=1.
//  - on_terminal=0, move_done=0, busy=0, FSM in IDLE.
//  Tile lookup:
//  - tile_h = x>>4 (0..19), tile_v = y>>4 (0..14).
//  - idx = (tile_h + tile_v*20)*3, computed at 10+ bits.
//  - Tile types: 0 NONE, 1 LINE, 2 TERMINAL; codes 3..7 are treated as NONE.
//  FSM IDLE->CALC->CHECK->COMMIT->IDLE, one cycle per state:
//  - IDLE: on frame_tick && game_en && !on_terminal -> CALC; otherwise stay.
//  - CALC: latch buttons; fixed priority up > down > left > right; one axis per frame.
//    Candidate = position -/+ STEP on the chosen axis. No button -> candidate = position.
//    btn_left sets dir=0, btn_right sets dir=1, in CALC, even if the move is later rejected.
//  - CHECK: register the candidate's tile type.
//    Out of range (X<H_MIN, X>H_MAX, Y<V_MIN, Y>V_MAX) forces NONE. Compare signed or
//    guarded: 8-2 must not wrap to 510.
//  - COMMIT: LINE or TERMINAL -> load candidate into charactor_h/v. NONE -> hold position.
//    TERMINAL -> on_terminal<=1. move_done=1 for this cycle only.
//  Outputs change only in COMMIT (position, on_terminal) or CALC (dir). Latency: position
//  valid 3 clk after frame_tick.
//  - frame_tick while busy is ignored, not queued.
//  - game_en falling mid-sequence: abort to IDLE next clk, no commit, no move_done.
//  - rst mid-sequence: all reset values next clk regardless of state.
//  - on_terminal sticky until rst; no further moves while set.
//  - map is sampled only in CHECK; changes at other times have no effect.
// TESTING
//  1. rst=1 then 0 -> h=24, v=24, dir=1, on_terminal=0, busy=0.
//  2. Tiles (1,1),(2,1) LINE; btn_right, 1 frame_tick -> h=26 after 3 clk, dir=1, move_done 1 clk.
//  3. Tile (1,0) NONE, at (24,16), btn_up, frame_tick -> v stays 16 (candidate tile NONE).
//  4. At h=8 on LINE, btn_left, frame_tick -> h stays 8, dir=0 (bound reject, no wrap to 510).
//  5. btn_up+btn_right with (1,1) LINE -> only v changes (24->22); dir unchanged.
//  6. Tile (2,1) TERMINAL, at (30,24), btn_right x2 frames -> on_terminal=1 after 1st commit;
//     2nd frame_tick: h stays 32, busy stays 0.
//  7. game_en dropped in CHECK -> no commit, no move_done; rst in CHECK -> all reset values.

Source files
------------

// File: rtl/charactor_motion.sv
// Sprite movement controller: turns one button request per video frame into a
// candidate position, checks the candidate's tile in the 20x15 map, and commits
// legal moves. Feeds position/facing into the screen stage and latches arrival
// on a TERMINAL tile.
module charactor_motion #(
    parameter int START_H = 24,
    parameter int START_V = 24,
    parameter int STEP    = 2,
    parameter int H_MIN   = 8,
    parameter int H_MAX   = 311,
    parameter int V_MIN   = 8,
    parameter int V_MAX   = 231
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         game_en,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic [0:899] map,
    output logic [8:0]   charactor_h,
    output logic [8:0]   charactor_v,
    output logic         charactor_dir,
    output logic         on_terminal,
    output logic         move_done,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [2:0] TILE_LINE     = 3'd1;
    localparam logic [2:0] TILE_TERMINAL = 3'd2;

    // Candidate arithmetic is carried at 11 bits signed so a step below zero
    // stays negative instead of wrapping into a large legal-looking X/Y.
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] H_MIN_S = 11'(H_MIN);
    localparam logic signed [10:0] H_MAX_S = 11'(H_MAX);
    localparam logic signed [10:0] V_MIN_S = 11'(V_MIN);
    localparam logic signed [10:0] V_MAX_S = 11'(V_MAX);

    state_t             state_q;
    logic [8:0]         h_q, v_q;
    logic               dir_q, term_q, done_q, busy_q;
    logic signed [10:0] cand_h_q, cand_v_q;
    logic [2:0]         tile_q;

    logic signed [10:0] cand_h_d, cand_v_d;
    logic               dir_d;
    logic               in_range;
    logic [4:0]         tile_h;
    logic [3:0]         tile_v;
    logic [9:0]         tile_lin;
    logic [9:0]         idx_d;
    logic [2:0]         tile_d;

    // Candidate position and facing from the buttons, fixed priority up>down>left>right
    always_comb begin
        cand_h_d = $signed({2'b00, h_q});
        cand_v_d = $signed({2'b00, v_q});
        dir_d    = dir_q;
        if (btn_up) begin
            cand_v_d = $signed({2'b00, v_q}) - STEP_S;
        end else if (btn_down) begin
            cand_v_d = $signed({2'b00, v_q}) + STEP_S;
        end else if (btn_left) begin
            cand_h_d = $signed({2'b00, h_q}) - STEP_S;
            dir_d    = 1'b0;
        end else if (btn_right) begin
            cand_h_d = $signed({2'b00, h_q}) + STEP_S;
            dir_d    = 1'b1;
        end
    end

    // Tile type under the latched candidate; off-field candidates read as NONE
    always_comb begin
        in_range = (cand_h_q >= H_MIN_S) && (cand_h_q <= H_MAX_S) &&
                   (cand_v_q >= V_MIN_S) && (cand_v_q <= V_MAX_S);
        tile_h   = cand_h_q[8:4];
        tile_v   = cand_v_q[7:4];
        tile_lin = 10'(tile_h) + 10'(tile_v) * 10'd20;
        idx_d    = in_range ? tile_lin * 10'd3 : '0;
        tile_d   = in_range ? map[idx_d +: 3] : 3'd0;
    end

    // Movement FSM with registered outputs; game_en loss aborts without commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            h_q      <= 9'(START_H);
            v_q      <= 9'(START_V);
            dir_q    <= 1'b1;
            term_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            cand_h_q <= '0;
            cand_v_q <= '0;
            tile_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_tick && game_en && !term_q) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                    end
                end
                CALC: begin
                    if (!game_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cand_h_q <= cand_h_d;
                        cand_v_q <= cand_v_d;
                        dir_q    <= dir_d;
                        state_q  <= CHECK;
                    end
                end
                CHECK: begin
                    if (!game_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        tile_q  <= tile_d;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (game_en) begin
                        if (tile_q == TILE_LINE || tile_q == TILE_TERMINAL) begin
                            h_q <= cand_h_q[8:0];
                            v_q <= cand_v_q[8:0];
                        end
                        if (tile_q == TILE_TERMINAL) begin
                            term_q <= 1'b1;
                        end
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign charactor_h   = h_q;
    assign charactor_v   = v_q;
    assign charactor_dir = dir_q;
    assign on_terminal   = term_q;
    assign move_done     = done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_charactor_motion.sv
// Bench for charactor_motion: table of per-frame moves with expected results
// queued at drive time and checked when move_done appears, plus hand-written
// sequences for terminal arrival, ignored ticks, game_en abort and reset.
module tb_charactor_motion;

    logic         clk;
    logic         rst;
    logic         frame_tick;
    logic         game_en;
    logic         btn_up, btn_down, btn_left, btn_right;
    logic [0:899] map_v;
    logic [8:0]   charactor_h, charactor_v;
    logic         charactor_dir, on_terminal, move_done, busy;

    int total;
    int bad;

    typedef struct {
        logic [3:0] btn;   // {up, down, left, right}
        logic [8:0] h;
        logic [8:0] v;
        logic       dir;
        logic       term;
    } vec_t;

    vec_t vecs[34];
    vec_t sb_q[$];

    charactor_motion dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .game_en      (game_en),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .map          (map_v),
        .charactor_h  (charactor_h),
        .charactor_v  (charactor_v),
        .charactor_dir(charactor_dir),
        .on_terminal  (on_terminal),
        .move_done    (move_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_tile(input int th, input int tv, input logic [2:0] code);
        logic [9:0] idx;
        idx = 10'((th + tv * 20) * 3);
        map_v[idx +: 3] = code;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One frame: drive tick, queue expectation, wait (bounded) for move_done.
    task automatic do_frame(input vec_t e, input int n);
        vec_t x;
        bit   seen;
        set_btn(e.btn);
        frame_tick = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        check($sformatf("busy_calc[%0d]", n), int'(busy), 1);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (move_done) seen = 1'b1;
        end
        check($sformatf("done_seen[%0d]", n), int'(seen), 1);
        x = sb_q.pop_front();
        if (seen) begin
            check($sformatf("h[%0d]", n), int'(charactor_h), int'(x.h));
            check($sformatf("v[%0d]", n), int'(charactor_v), int'(x.v));
            check($sformatf("dir[%0d]", n), int'(charactor_dir), int'(x.dir));
            check($sformatf("term[%0d]", n), int'(on_terminal), int'(x.term));
            @(negedge clk);
            check($sformatf("done_pulse[%0d]", n), int'(move_done), 0);
        end
        set_btn(4'b0000);
    endtask

    initial begin
        int   dones;
        bit   busy_seen;
        vec_t t;

        total = 0;
        bad   = 0;
        rst = 1'b1; frame_tick = 1'b0; game_en = 1'b1;
        set_btn(4'b0000);
        map_v = '0;
        set_tile(0, 1, 3'd1);
        set_tile(1, 1, 3'd1);
        set_tile(2, 1, 3'd1);
        set_tile(1, 0, 3'd0);
        set_tile(1, 2, 3'd5);

        // {U,D,L,R}, expected h, v, dir, term after the frame
        vecs[0]  = '{4'b0001, 9'd26, 9'd24, 1'b1, 1'b0};
        vecs[1]  = '{4'b0010, 9'd24, 9'd24, 1'b0, 1'b0};
        vecs[2]  = '{4'b1000, 9'd24, 9'd22, 1'b0, 1'b0};
        vecs[3]  = '{4'b1000, 9'd24, 9'd20, 1'b0, 1'b0};
        vecs[4]  = '{4'b1000, 9'd24, 9'd18, 1'b0, 1'b0};
        vecs[5]  = '{4'b1000, 9'd24, 9'd16, 1'b0, 1'b0};
        vecs[6]  = '{4'b1000, 9'd24, 9'd16, 1'b0, 1'b0};  // tile (1,0) NONE
        vecs[7]  = '{4'b1001, 9'd24, 9'd16, 1'b0, 1'b0};  // up wins, rejected, dir kept
        vecs[8]  = '{4'b0100, 9'd24, 9'd18, 1'b0, 1'b0};
        vecs[9]  = '{4'b0001, 9'd26, 9'd18, 1'b1, 1'b0};
        vecs[10] = '{4'b1010, 9'd26, 9'd16, 1'b1, 1'b0};  // up wins, dir kept
        vecs[11] = '{4'b0000, 9'd26, 9'd16, 1'b1, 1'b0};
        vecs[12] = '{4'b0010, 9'd24, 9'd16, 1'b0, 1'b0};
        vecs[13] = '{4'b0100, 9'd24, 9'd18, 1'b0, 1'b0};
        vecs[14] = '{4'b0100, 9'd24, 9'd20, 1'b0, 1'b0};
        vecs[15] = '{4'b0100, 9'd24, 9'd22, 1'b0, 1'b0};
        vecs[16] = '{4'b0100, 9'd24, 9'd24, 1'b0, 1'b0};
        vecs[17] = '{4'b0100, 9'd24, 9'd26, 1'b0, 1'b0};
        vecs[18] = '{4'b0100, 9'd24, 9'd28, 1'b0, 1'b0};
        vecs[19] = '{4'b0100, 9'd24, 9'd30, 1'b0, 1'b0};
        vecs[20] = '{4'b0100, 9'd24, 9'd30, 1'b0, 1'b0};  // tile (1,2) code 5 -> NONE
        vecs[21] = '{4'b0011, 9'd22, 9'd30, 1'b0, 1'b0};  // left beats right
        vecs[22] = '{4'b0010, 9'd20, 9'd30, 1'b0, 1'b0};
        vecs[23] = '{4'b0010, 9'd18, 9'd30, 1'b0, 1'b0};
        vecs[24] = '{4'b0010, 9'd16, 9'd30, 1'b0, 1'b0};
        vecs[25] = '{4'b0010, 9'd14, 9'd30, 1'b0, 1'b0};
        vecs[26] = '{4'b0010, 9'd12, 9'd30, 1'b0, 1'b0};
        vecs[27] = '{4'b0010, 9'd10, 9'd30, 1'b0, 1'b0};
        vecs[28] = '{4'b0010, 9'd8,  9'd30, 1'b0, 1'b0};
        vecs[29] = '{4'b0001, 9'd10, 9'd30, 1'b1, 1'b0};
        vecs[30] = '{4'b0010, 9'd8,  9'd30, 1'b0, 1'b0};
        vecs[31] = '{4'b0010, 9'd8,  9'd30, 1'b0, 1'b0};  // 6 < H_MIN, no wrap
        vecs[32] = '{4'b0001, 9'd10, 9'd30, 1'b1, 1'b0};
        vecs[33] = '{4'b0010, 9'd8,  9'd30, 1'b0, 1'b0};

        // Reset state
        do_reset();
        check("rst_h", int'(charactor_h), 24);
        check("rst_v", int'(charactor_v), 24);
        check("rst_dir", int'(charactor_dir), 1);
        check("rst_term", int'(on_terminal), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(move_done), 0);

        for (int i = 0; i < 34; i++) do_frame(vecs[i], i);

        // Terminal arrival, then further ticks ignored
        set_tile(2, 1, 3'd2);
        do_reset();
        t = '{4'b0001, 9'd26, 9'd24, 1'b1, 1'b0}; do_frame(t, 100);
        t = '{4'b0001, 9'd28, 9'd24, 1'b1, 1'b0}; do_frame(t, 101);
        t = '{4'b0001, 9'd30, 9'd24, 1'b1, 1'b0}; do_frame(t, 102);
        t = '{4'b0001, 9'd32, 9'd24, 1'b1, 1'b1}; do_frame(t, 103);
        set_btn(4'b0001);
        frame_tick = 1'b1;
        busy_seen = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (move_done) dones++;
        end
        set_btn(4'b0000);
        check("term_busy", int'(busy_seen), 0);
        check("term_done", dones, 0);
        check("term_h", int'(charactor_h), 32);
        check("term_sticky", int'(on_terminal), 1);

        // Tick while busy is dropped, not queued
        do_reset();
        set_btn(4'b0001);
        frame_tick = 1'b1;
        @(negedge clk);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            frame_tick = (i < 2);
            if (move_done) dones++;
        end
        frame_tick = 1'b0;
        set_btn(4'b0000);
        check("busy_tick_dones", dones, 1);
        check("busy_tick_h", int'(charactor_h), 26);

        // game_en dropped during CHECK: abort, no commit
        do_reset();
        set_btn(4'b0001);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        game_en = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (move_done) dones++;
        end
        check("abort_done", dones, 0);
        check("abort_h", int'(charactor_h), 24);
        check("abort_busy", int'(busy), 0);
        game_en = 1'b1;
        set_btn(4'b0000);

        // rst during CHECK restores all reset values
        t = '{4'b0010, 9'd22, 9'd24, 1'b0, 1'b0}; do_frame(t, 200);
        set_btn(4'b0010);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_h", int'(charactor_h), 24);
        check("rstmid_v", int'(charactor_v), 24);
        check("rstmid_dir", int'(charactor_dir), 1);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_done", int'(move_done), 0);
        check("rstmid_term", int'(on_terminal), 0);
        rst = 1'b0;
        set_btn(4'b0000);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
